// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - START/END/ESC framing of a UART byte stream, payload replayed over valid/ready.
// Optional inter-byte timeout in RECV/ESC is enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_decoder #(
    parameter int         MAX_LEN    = 16,
    parameter logic [7:0] START_CHAR = 8'h01,
    parameter logic [7:0] END_CHAR   = 8'h17,
    parameter logic [7:0] ESC_CHAR   = 8'h18,
`ifdef FRAME_TIMEOUT_EN
    parameter int         TIMEOUT_CYCLES = 120000,
`endif
    parameter int         LW         = $clog2(MAX_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_drdy_i,
    output logic          rx_busy_o,
    output logic [7:0]    frame_data_o,
    output logic          frame_valid_o,
    input  logic          frame_ready_i,
    output logic          frame_last_o,
    output logic [LW-1:0] frame_len_o,
    output logic          frame_err_o,
    output logic [2:0]    err_code_o
);

    localparam int            AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LW-1:0] FULL = LW'(MAX_LEN);
    localparam logic [2:0]    E_OVERFLOW = 3'd1;
    localparam logic [2:0]    E_ABORT    = 3'd2;
    localparam logic [2:0]    E_OVERRUN  = 3'd3;
`ifdef FRAME_TIMEOUT_EN
    localparam logic [2:0]    E_TIMEOUT  = 3'd4;
    localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_ESC, S_DRAIN} state_t;

    state_t        state_q;
    logic [LW-1:0] wr_ptr_q, rd_ptr_q, frame_len_q;
    logic [7:0]    frame_data_q;
    logic          frame_valid_q, frame_last_q, busy_q, frame_err_q;
    logic [2:0]    err_code_q;
    logic [7:0]    mem_q [2**AW];

    logic store_byte, full, mem_we, final_hs;

    // In ESC every byte is literal; in RECV only non-control bytes are payload.
    assign store_byte = rx_drdy_i && ((state_q == S_ESC) ||
                        (state_q == S_RECV && rx_data_i != ESC_CHAR &&
                         rx_data_i != END_CHAR && rx_data_i != START_CHAR));
    assign full     = (wr_ptr_q == FULL);
    assign mem_we   = store_byte && !full;
    assign final_hs = (state_q == S_DRAIN) && frame_valid_q && frame_ready_i && frame_last_q;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            frame_len_q   <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_last_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= '0;
`ifdef FRAME_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_drdy_i && rx_data_i == START_CHAR) begin
                        state_q  <= S_RECV;
                        wr_ptr_q <= '0;
                    end
                end
                S_RECV, S_ESC: begin
                    if (store_byte) begin
                        if (full) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= E_OVERFLOW;
                            state_q     <= S_IDLE;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            state_q  <= S_RECV;
                        end
                    end else if (rx_drdy_i && rx_data_i == ESC_CHAR) begin
                        state_q <= S_ESC;
                    end else if (rx_drdy_i && rx_data_i == END_CHAR) begin
                        if (wr_ptr_q == '0) begin
                            state_q <= S_IDLE;
                        end else begin
                            frame_len_q <= wr_ptr_q;
                            rd_ptr_q    <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_DRAIN;
                        end
                    end else if (rx_drdy_i && rx_data_i == START_CHAR) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= E_ABORT;
                        wr_ptr_q    <= '0;
                    end
                end
                S_DRAIN: begin
                    if (rx_drdy_i && !final_hs) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= E_OVERRUN;
                    end
                    // Idle cycle between bytes doubles as the registered memory read.
                    if (!frame_valid_q) begin
                        frame_data_q  <= mem_q[rd_ptr_q[AW-1:0]];
                        frame_valid_q <= 1'b1;
                        frame_last_q  <= (rd_ptr_q == frame_len_q - LW'(1));
                    end else if (frame_ready_i) begin
                        frame_valid_q <= 1'b0;
                        frame_last_q  <= 1'b0;
                        if (frame_last_q) begin
                            busy_q   <= 1'b0;
                            rd_ptr_q <= '0;
                            wr_ptr_q <= '0;
                            state_q  <= (rx_drdy_i && rx_data_i == START_CHAR) ? S_RECV : S_IDLE;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef FRAME_TIMEOUT_EN
            if ((state_q == S_RECV || state_q == S_ESC) && !rx_drdy_i) begin
                if (tmo_q == TMO_LAST) begin
                    frame_err_q <= 1'b1;
                    err_code_q  <= E_TIMEOUT;
                    state_q     <= S_IDLE;
                    tmo_q       <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

    assign rx_busy_o     = busy_q;
    assign frame_data_o  = frame_data_q;
    assign frame_valid_o = frame_valid_q;
    assign frame_last_o  = frame_last_q;
    assign frame_len_o   = frame_len_q;
    assign frame_err_o   = frame_err_q;
    assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - scoreboard bench for uart_frame_decoder with MAX_LEN=4.
module tb_uart_frame_decoder;

    localparam int MAX_LEN = 4;
    localparam int LW      = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_drdy = 1'b0;
    logic          rx_busy;
    logic [7:0]    frame_data;
    logic          frame_valid;
    logic          frame_ready = 1'b1;
    logic          frame_last;
    logic [LW-1:0] frame_len;
    logic          frame_err;
    logic [2:0]    err_code;

    uart_frame_decoder #(.MAX_LEN(MAX_LEN), .LW(LW)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .rx_data_i(rx_data), .rx_drdy_i(rx_drdy),
        .rx_busy_o(rx_busy), .frame_data_o(frame_data), .frame_valid_o(frame_valid),
        .frame_ready_i(frame_ready), .frame_last_o(frame_last), .frame_len_o(frame_len),
        .frame_err_o(frame_err), .err_code_o(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         len;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    logic [7:0] payload[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'(frame_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("data", int'(frame_data), int'(e.d));
                    check("last", int'(frame_last), int'(e.l));
                    check("len", int'(frame_len), e.len);
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) check("unexpected_err", int'(err_code), 0);
                else check("err_code", int'(err_code), err_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) frame_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_drdy = 1'b1;
        @(posedge clk); #1;
        rx_drdy = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l, input int len);
        exp_t e;
        e.d = d; e.l = l; e.len = len;
        exp_q.push_back(e);
    endtask

    // Escapes any control byte in the payload and records the expected replay.
    task automatic send_frame();
        send_byte(8'h01);
        foreach (payload[i]) begin
            push_exp(payload[i], i == payload.size() - 1, payload.size());
            if (payload[i] == 8'h01 || payload[i] == 8'h17 || payload[i] == 8'h18)
                send_byte(8'h18);
            send_byte(payload[i]);
        end
        send_byte(8'h17);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!rx_busy && !frame_valid) return;
        end
        check("drain_timeout", 1, 0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (frame_valid) return;
        end
        check("valid_timeout", 1, 0);
    endtask

    task automatic check_queues(input string tag);
        @(negedge clk);
        check({tag, "_bytes_left"}, exp_q.size(), 0);
        check({tag, "_errs_left"}, err_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(rx_busy), 0);
        check({tag, "_valid"}, int'(frame_valid), 0);
        check({tag, "_data"}, int'(frame_data), 0);
        check({tag, "_last"}, int'(frame_last), 0);
        check({tag, "_len"}, int'(frame_len), 0);
        check({tag, "_err"}, int'(frame_err), 0);
        check({tag, "_code"}, int'(err_code), 0);
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic frame plus first-byte latency relative to the END strobe.
        push_exp(8'h41, 1'b0, 3); push_exp(8'h42, 1'b0, 3); push_exp(8'h43, 1'b1, 3);
        send_byte(8'h01); send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
        send_byte(8'h17);
        @(negedge clk); check("lat_not_yet", int'(frame_valid), 0);
        check("busy_drain", int'(rx_busy), 1);
        @(negedge clk); check("lat_first", int'(frame_valid), 1);
        wait_idle();
        check_queues("basic");

        // Escaped control characters are payload.
        push_exp(8'h17, 1'b0, 3); push_exp(8'h01, 1'b0, 3); push_exp(8'h18, 1'b1, 3);
        send_byte(8'h01); send_byte(8'h18); send_byte(8'h17); send_byte(8'h18);
        send_byte(8'h01); send_byte(8'h18); send_byte(8'h18); send_byte(8'h17);
        wait_idle();
        check_queues("escape");

        // Overflow on the fifth store, trailing END ignored, then recovery.
        err_q.push_back(1);
        send_byte(8'h01);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        send_byte(8'h17);
        repeat (4) @(negedge clk);
        check("ovf_no_busy", int'(rx_busy), 0);
        push_exp(8'h55, 1'b1, 1);
        send_byte(8'h01); send_byte(8'h55); send_byte(8'h17);
        wait_idle();
        check("err_code_hold", int'(err_code), 1);
        check_queues("overflow");

        // Exactly MAX_LEN bytes is a full, legal frame.
        payload = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        send_frame();
        wait_idle();
        check_queues("full_len");

        // Second START mid-frame aborts the partial frame.
        err_q.push_back(2);
        push_exp(8'hBB, 1'b1, 1);
        send_byte(8'h01); send_byte(8'hAA); send_byte(8'h01); send_byte(8'hBB);
        send_byte(8'h17);
        wait_idle();
        check_queues("abort");

        // Empty frame produces nothing.
        send_byte(8'h01); send_byte(8'h17);
        repeat (4) @(negedge clk);
        check("empty_busy", int'(rx_busy), 0);
        check_queues("empty");

        // Byte arriving while draining is an overrun; payload stays intact.
        frame_ready = 1'b0;
        push_exp(8'h11, 1'b0, 2); push_exp(8'h22, 1'b1, 2);
        send_byte(8'h01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h17);
        err_q.push_back(3);
        send_byte(8'h33);
        @(negedge clk);
        check("overrun_busy", int'(rx_busy), 1);
        check("overrun_code", int'(err_code), 3);
        @(posedge clk); #1;
        frame_ready = 1'b1;
        wait_idle();
        check_queues("overrun");

        // START coinciding with the final handshake opens a new frame.
        frame_ready = 1'b0;
        push_exp(8'h77, 1'b1, 1);
        send_byte(8'h01); send_byte(8'h77); send_byte(8'h17);
        wait_valid();
        @(posedge clk); #1;
        frame_ready = 1'b1;
        rx_data = 8'h01;
        rx_drdy = 1'b1;
        @(posedge clk); #1;
        rx_drdy = 1'b0;
        push_exp(8'h66, 1'b1, 1);
        send_byte(8'h66); send_byte(8'h17);
        wait_idle();
        check_queues("start_on_last");

        // Random payloads (control bytes escaped) with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            int len;
            len = $urandom_range(1, MAX_LEN);
            payload.delete();
            for (int i = 0; i < len; i++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) b = 8'h17 + 8'($urandom_range(0, 1));
                payload.push_back(b);
            end
            send_frame();
            wait_idle();
        end
        rand_ready = 1'b0;
        #1 frame_ready = 1'b1;
        check_queues("random");

        // Reset mid-frame: partial frame gone, stray END ignored.
        send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        apply_reset("rst_recv");
        send_byte(8'h17);
        repeat (4) @(negedge clk);
        check("rst_recv_idle", int'(rx_busy), 0);
        push_exp(8'hCC, 1'b1, 1);
        send_byte(8'h01); send_byte(8'hCC); send_byte(8'h17);
        wait_idle();
        check_queues("rst_recv");

        // Reset mid-drain: buffered byte discarded.
        frame_ready = 1'b0;
        send_byte(8'h01); send_byte(8'h5A); send_byte(8'h17);
        wait_valid();
        apply_reset("rst_drain");
        frame_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_drain_valid", int'(frame_valid), 0);
        check_queues("rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
